// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and fetch-stage state encoding used across the core.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Wait-cycle counter for an outstanding instruction-memory request.
module fetch_watchdog #(
  parameter int TimeoutCycles = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Expiry fires in the wait cycle whose increment would reach TimeoutCycles.
  localparam logic [7:0] LastCount = 8'(TimeoutCycles - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = enable && (count == LastCount);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, valid/ready output to decode,
// next-PC selection from the execute-stage redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int               Width         = 32,
  parameter logic [Width-1:0] ResetPC       = '0,
  parameter int               TimeoutCycles = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrc,
  input  logic [Width-1:0] PCTarget,
  input  logic             instr_ready,
  output logic             instr_valid,
  output logic [31:0]      Instr,
  output logic [Width-1:0] PC,
  output logic [Width-1:0] PCPlus4,
  output logic             imem_req,
  output logic [Width-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             misalign_err,
  output logic             imem_timeout
);

  fetch_state_e     state, state_next;
  logic [Width-1:0] pc_q;
  logic [Width-1:0] next_pc;
  logic [31:0]      instr_q;
  logic             misalign_q;
  logic             timeout_q;
  logic             wd_expired;
  logic             handshake;
  logic             rvalid_take;

  assign handshake   = (state == S_VALID) && instr_ready;
  assign rvalid_take = (state == S_WAIT) && imem_rvalid;

  fetch_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == S_REQ),
    .enable (state == S_WAIT),
    .expired(wd_expired)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_REQ;
      S_REQ:   state_next = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          state_next = S_VALID;
        end else if (wd_expired) begin
          state_next = S_REQ;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign PCPlus4 = pc_q + Width'(4);
  // A misaligned redirect is still followed, rounded down to the word boundary.
  assign next_pc = PCSrc ? {PCTarget[Width-1:2], 2'b00} : PCPlus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc_q       <= ResetPC;
      instr_q    <= NOP_INSTR;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (handshake) begin
        pc_q <= next_pc;
      end
      if (handshake && PCSrc && (PCTarget[1:0] != 2'b00)) begin
        misalign_q <= 1'b1;
      end
      if (rvalid_take) begin
        instr_q <= imem_rdata;
      end
      if ((state == S_WAIT) && !imem_rvalid && wd_expired) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign instr_valid  = (state == S_VALID);
  assign imem_req     = (state == S_REQ);
  assign imem_addr    = {pc_q[Width-1:2], 2'b00};
  assign Instr        = instr_q;
  assign PC           = pc_q;
  assign misalign_err = misalign_q;
  assign imem_timeout = timeout_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model pushes each returned word, and the
// handshake with decode pops and compares it against a reference PC model.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int TimeoutCycles = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  logic        clk;
  logic        reset;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        misalign_err;
  logic        imem_timeout;

  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        spur_rvalid;
  int          mem_latency;
  int          mem_drop;

  sb_entry_t   sb_q[$];
  logic [31:0] exp_pc;
  logic        exp_mis;
  int          total;
  int          bad;

  assign imem_rvalid = mem_rvalid | spur_rvalid;
  assign imem_rdata  = spur_rvalid ? 32'hDEAD_BEEF : mem_rdata;

  fetch_unit #(
    .Width        (32),
    .ResetPC      (32'h0000_0000),
    .TimeoutCycles(TimeoutCycles)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .instr_ready (instr_ready),
    .instr_valid (instr_valid),
    .Instr       (Instr),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .misalign_err(misalign_err),
    .imem_timeout(imem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[24:0], OP_ADDI};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      step();
      n++;
    end
    checkOutput("req_seen", imem_req, 1);
    checkOutput("req_addr", imem_addr, exp_pc);
  endtask

  // Waits for a presented instruction, optionally stalls, then completes the handshake.
  task automatic applyStimulus(input int stall, input logic src, input logic [31:0] target);
    int n = 0;
    sb_entry_t e;
    while (!instr_valid && n < 50) begin
      step();
      n++;
    end
    checkOutput("valid_seen", instr_valid, 1);
    for (int i = 0; i < stall; i++) begin
      spur_rvalid = i[0];
      step();
      checkOutput("hold_instr", Instr, (sb_q.size() > 0) ? sb_q[0].data : 'x);
      checkOutput("hold_pc", PC, exp_pc);
      checkOutput("hold_valid", instr_valid, 1);
      checkOutput("hold_noreq", imem_req, 0);
    end
    spur_rvalid = 1'b0;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
    end else begin
      e.addr = 'x;
      e.data = 'x;
    end
    checkOutput("instr", Instr, e.data);
    checkOutput("pc_sb", PC, e.addr);
    checkOutput("pc_model", PC, exp_pc);
    checkOutput("pcplus4", PCPlus4, exp_pc + 32'd4);
    instr_ready = 1'b1;
    PCSrc       = src;
    PCTarget    = target;
    step();
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    PCTarget    = $urandom;
    if (src && target[1:0] != 2'b00) exp_mis = 1'b1;
    exp_pc = src ? {target[31:2], 2'b00} : exp_pc + 32'd4;
    checkOutput("misalign", misalign_err, exp_mis);
  endtask

  // Memory model: answers each request after mem_latency cycles unless told to drop it.
  initial begin
    logic [31:0] a;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      step();
      if (imem_req) begin
        a = imem_addr;
        if (mem_drop > 0) begin
          mem_drop--;
        end else begin
          step();
          repeat (mem_latency - 1) step();
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(a);
          sb_q.push_back('{addr: a, data: mem_word(a)});
          step();
          mem_rvalid = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int cnt;
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    PCSrc       = 1'b0;
    PCTarget    = '0;
    instr_ready = 1'b0;
    spur_rvalid = 1'b0;
    mem_latency = 1;
    mem_drop    = 0;
    exp_pc      = 32'h0;
    exp_mis     = 1'b0;
    repeat (3) step();

    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_instr", Instr, NOP_INSTR);
    checkOutput("rst_pc", PC, 32'h0);
    checkOutput("rst_pc4", PCPlus4, 32'h4);
    checkOutput("rst_mis", misalign_err, 0);
    checkOutput("rst_tmo", imem_timeout, 0);

    // First fetch timing: IDLE, REQ, WAIT, VALID.
    reset = 1'b0;
    checkOutput("c1_noreq", imem_req, 0);
    step();
    checkOutput("c2_req", imem_req, 1);
    checkOutput("c2_addr", imem_addr, 32'h0);
    step();
    checkOutput("c3_req_low", imem_req, 0);
    checkOutput("c3_valid_low", instr_valid, 0);
    step();
    checkOutput("c4_valid", instr_valid, 1);
    applyStimulus(0, 1'b0, 32'h0);
    wait_req();

    // Redirect, then sequential.
    applyStimulus(0, 1'b1, 32'h0000_0100);
    wait_req();
    applyStimulus(0, 1'b0, 32'h0);
    wait_req();

    // Backpressure with spurious responses, slower memory.
    mem_latency = 3;
    applyStimulus(10, 1'b0, 32'h0);
    wait_req();
    mem_latency = 1;

    // Timeout and reissue of the same address.
    mem_drop = 1;
    applyStimulus(0, 1'b0, 32'h0);
    wait_req();
    checkOutput("tmo_before", imem_timeout, 0);
    cnt = 0;
    do begin
      step();
      cnt++;
      if (cnt == TimeoutCycles) checkOutput("tmo_last_wait", imem_timeout, 0);
    end while (!imem_req && cnt < 20);
    checkOutput("tmo_gap", cnt, TimeoutCycles + 1);
    checkOutput("tmo_flag", imem_timeout, 1);
    checkOutput("tmo_reissue", imem_addr, exp_pc);

    // Misaligned redirect.
    applyStimulus(0, 1'b1, 32'h0000_0103);
    wait_req();
    checkOutput("tmo_sticky", imem_timeout, 1);

    // Wrap from the top of the address space.
    applyStimulus(0, 1'b1, 32'hFFFF_FFFC);
    wait_req();
    mem_drop = 1;
    applyStimulus(0, 1'b0, 32'h0);
    checkOutput("wrap_pc", PC, 32'h0);
    wait_req();
    checkOutput("mis_sticky", misalign_err, 1);

    // Reset while waiting on memory.
    step();
    reset = 1'b1;
    step();
    checkOutput("mid_rst_valid", instr_valid, 0);
    checkOutput("mid_rst_req", imem_req, 0);
    checkOutput("mid_rst_mis", misalign_err, 0);
    checkOutput("mid_rst_tmo", imem_timeout, 0);
    sb_q.delete();
    exp_pc  = 32'h0;
    exp_mis = 1'b0;
    reset   = 1'b0;
    wait_req();
    applyStimulus(0, 1'b0, 32'h0);
    wait_req();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the main/ALU decoder.
- Holds the architectural PC and issues one request at a time to instruction memory over a req/rvalid interface.
- Captures the returned word and presents it, with PC and PC+4, to decode/execute under a valid/ready handshake.
- Consumes the execute-stage redirect (PCSrc, PCTarget) to select the next PC.

Parameters:
- Width, 32, datapath/PC width in bits.
- ResetPC, 32'h0000_0000, PC value after reset.
- TimeoutCycles, 255, maximum wait cycles for imem_rvalid before the request is reissued (range 1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- PCSrc  in  1  redirect select from controller; sampled only on handshake.
- PCTarget  in  Width  branch/jump target; sampled only on handshake.
- instr_ready  in  1  consumer executes the presented instruction this cycle.
- instr_valid  out  1  Instr/PC/PCPlus4 are valid.
- Instr  out  32  captured instruction word.
- PC  out  Width  address of Instr.
- PCPlus4  out  Width  PC + 4.
- imem_req  out  1  one-cycle request pulse.
- imem_addr  out  Width  request address, bits [1:0] always 0.
- imem_rvalid  in  1  response strobe.
- imem_rdata  in  32  response data.
- misalign_err  out  1  sticky: redirect target had nonzero [1:0].
- imem_timeout  out  1  sticky: at least one request timed out.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), and it dominates all other inputs in the cycle it is asserted.
- Reset values:
  - state=S_IDLE, PC=ResetPC, Instr=32'h0000_0013 (nop), instr_valid=0.
  - imem_req=0, imem_addr=ResetPC with [1:0] forced to 0.
  - misalign_err=0, imem_timeout=0, wait counter=0.
- S_IDLE: one cycle after reset deasserts; req=0; -> S_REQ.
- S_REQ: imem_req=1, imem_addr={PC[Width-1:2],2'b00}; counter cleared; -> S_WAIT unconditionally. An rvalid in this cycle is ignored.
- S_WAIT: req=0; counter increments each cycle.
  - On rvalid: Instr<=imem_rdata, -> S_VALID.
  - Otherwise, when counter reaches TimeoutCycles: imem_timeout<=1, -> S_REQ (reissue the same PC).
  - rvalid takes priority over timeout in the same cycle.
- S_VALID: instr_valid=1; Instr/PC/PCPlus4 held stable.
  - On instr_ready: PC<=PCSrc ? PCTarget : PCPlus4; -> S_REQ.
  - If PCSrc=1 and PCTarget[1:0]!=0: misalign_err<=1, and PC gets PCTarget with [1:0] cleared.
- instr_ready outside S_VALID is ignored. PCSrc/PCTarget are never sampled outside the handshake.
- PCPlus4 = PC + 4, truncated to Width bits (wraps from all-ones region to 0; no flag).
- Minimum throughput: 3 cycles per instruction (REQ, WAIT with rvalid, VALID with ready).
- Any rvalid arriving in S_IDLE, S_REQ or S_VALID is dropped.
- A late response to a timed-out request, arriving in the reissue's S_WAIT, is accepted; it is the same address.
- The memory contract is at most one response per request.
- Reset mid-fetch: the outstanding transaction is abandoned and the next request starts from ResetPC.
- Sticky flags clear only on reset.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - Opcode constants (OP_LW, OP_ADDI, OP_SW, OP_R, OP_BEQ, OP_JAL).
  - Fetch-state enum encoding (S_IDLE, S_REQ, S_WAIT, S_VALID).
- One sub-module, fetch_watchdog: 8-bit wait counter with clear/enable/expired inputs and outputs, parameterised by TimeoutCycles.
- The PC register, PC adder and next-PC mux stay inline.

Test Plan:
- Reset release with memory answering one cycle after req: imem_req pulses at cycle 2 with addr 0x0; instr_valid rises at cycle 4 with Instr=rdata, PC=0x0, PCPlus4=0x4; with instr_ready held high, next req goes to 0x4.
- Redirect: at handshake with PCSrc=1, PCTarget=0x100, next imem_addr=0x100 and PC=0x100. With PCSrc=0, next address=old PC+4.
- Backpressure: instr_ready held low for 10 cycles. Instr/PC stay constant, no imem_req issues, and rvalid pulses during this window are ignored.
- Timeout: no rvalid for TimeoutCycles=4 cycles. imem_timeout sets and imem_req reissues the same address; a response then completes normally.
- Misaligned target 0x103 with PCSrc=1: misalign_err=1 and imem_addr=0x100. Flag persists until reset.
- Wrap and reset: PC=0xFFFF_FFFC with PCSrc=0 gives next PC=0x0. Asserting reset in S_WAIT leaves instr_valid=0, and the next request goes to ResetPC.
